// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the radix-4 sequential multiplier controller.
package mult_ctrl_pkg;

  // Recoding schemes selectable at operand accept; 2'd3 behaves like MB.
  localparam logic [1:0] MODE_MB     = 2'd0;
  localparam logic [1:0] MODE_NR4SDM = 2'd1;
  localparam logic [1:0] MODE_NR4SDP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One radix-4 digit in sign/magnitude one-hot form; all zero means d=0.
  typedef struct packed {
    logic one;
    logic two;
    logic neg;
  } digit_t;

  // Both non-redundant schemes share the carry chain and the special last digit.
  function automatic logic is_nr4sd(input logic [1:0] mode);
    return (mode == MODE_NR4SDM) || (mode == MODE_NR4SDP);
  endfunction

endpackage

// File: rtl/radix4_digit_recoder.sv
// Combinational recoder: turns one multiplier bit pair (plus the previous bit
// or the running carry) into a signed radix-4 digit in {-2..2}.
module radix4_digit_recoder
  import mult_ctrl_pkg::*;
(
  input  logic [1:0] b2,        // bits 2j+1, 2j
  input  logic       b_prev,    // bit 2j-1 (0 for j=0)
  input  logic       carry_in,
  input  logic [1:0] mode,
  input  logic       last,      // j == ITER-1
  output logic       one,
  output logic       two,
  output logic       neg,
  output logic       carry_out
);

  logic signed [3:0] d;
  logic [2:0]        v;

  // Pick the digit value for the active scheme, then derive the one-hot encoding.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/case can leave it unassigned and infer a latch.
    d         = 4'sd0;
    carry_out = 1'b0;
    v         = {1'b0, b2[1], 1'b0} + {2'b00, b2[0]} + {2'b00, carry_in};
    if (!is_nr4sd(mode)) begin
      // Modified Booth: overlapping triplet, no carry.
      d = 4'sd0 - (b2[1] ? 4'sd2 : 4'sd0) + (b2[0] ? 4'sd1 : 4'sd0)
                + (b_prev ? 4'sd1 : 4'sd0);
    end else if (last) begin
      // Top digit absorbs the sign bit and the pending carry directly.
      d = 4'sd0 - (b2[1] ? 4'sd2 : 4'sd0) + (b2[0] ? 4'sd1 : 4'sd0)
                + (carry_in ? 4'sd1 : 4'sd0);
    end else begin
      case (v)
        3'd0:    d = 4'sd0;
        3'd1:    d = 4'sd1;
        3'd2: begin
          // NR4SD+ keeps +2; NR4SD- folds it into -2 with a carry.
          if (mode == MODE_NR4SDP) begin
            d = 4'sd2;
          end else begin
            d         = -4'sd2;
            carry_out = 1'b1;
          end
        end
        3'd3: begin
          d         = -4'sd1;
          carry_out = 1'b1;
        end
        3'd4: begin
          d         = 4'sd0;
          carry_out = 1'b1;
        end
        default: d = 4'sd0;
      endcase
    end
  end

  assign one = (d == 4'sd1) || (d == -4'sd1);
  assign two = (d == 4'sd2) || (d == -4'sd2);
  assign neg = d[3];

endmodule

// File: rtl/radix4_seq_mult_ctrl.sv
// Iterative signed WIDTH x WIDTH multiplier: one radix-4 partial-product row
// per clock, accumulated at weight 4^j over WIDTH/2 cycles.
module radix4_seq_mult_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int ITER  = WIDTH / 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         mode,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               dbg_one,
  output logic               dbg_two,
  output logic               dbg_neg
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   j_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [1:0]         mode_q;
  logic [2*WIDTH-1:0] acc_q;

  logic               accept;
  logic               last_digit;
  logic [WIDTH:0]     b_ext;
  logic [2:0]         b_win;
  logic               dig_one, dig_two, dig_neg, carry_next;
  digit_t             digit;
  logic [WIDTH+1:0]   a_ext, mag, row;
  logic [2*WIDTH-1:0] row_ext, acc_next;

  assign accept     = in_valid & in_ready & ~flush;
  assign last_digit = (j_q == CNT_W'(ITER - 1));

  // b with the implicit b[-1]=0 appended; the window for digit j starts at bit 2j.
  assign b_ext = {b_q, 1'b0};
  assign b_win = 3'(b_ext >> {j_q, 1'b0});

  radix4_digit_recoder u_recoder (
    .b2        (b_win[2:1]),
    .b_prev    (b_win[0]),
    .carry_in  (carry_q),
    .mode      (mode_q),
    .last      (last_digit),
    .one       (dig_one),
    .two       (dig_two),
    .neg       (dig_neg),
    .carry_out (carry_next)
  );

  assign digit = '{one: dig_one, two: dig_two, neg: dig_neg};

  // Row = d*A in WIDTH+2 bits (holds +/-2^WIDTH), then placed at weight 4^j.
  assign a_ext    = {{2{a_q[WIDTH-1]}}, a_q};
  assign mag      = digit.two ? {a_ext[WIDTH:0], 1'b0} : (digit.one ? a_ext : '0);
  assign row      = digit.neg ? (~mag + 1'b1) : mag;
  assign row_ext  = {{(WIDTH-2){row[WIDTH+1]}}, row};
  assign acc_next = acc_q + (row_ext << {j_q, 1'b0});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides accept and out_ready from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)     state_d = ST_RUN;
      ST_RUN:  if (last_digit) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Operand latch, digit counter, recode carry and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset as well, so product and the
    // recode carry come up at zero and an interrupted operation leaves nothing
    // behind; they are few and narrow, unlike a memory array.
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= MODE_MB;
      j_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      mode_q  <= mode;
      j_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
    end else if ((state_q == ST_RUN) && !flush) begin
      acc_q   <= acc_next;
      j_q     <= j_q + CNT_W'(1);
      carry_q <= carry_next;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_DONE);
  assign product   = out_valid ? acc_q : '0;
  assign dbg_one   = busy & digit.one;
  assign dbg_two   = busy & digit.two;
  assign dbg_neg   = busy & digit.neg;

endmodule

// File: doc/radix4_seq_mult_ctrl.md
Name: radix4_seq_mult_ctrl

Overview:
- Iterative signed WIDTH x WIDTH multiplier controller. It time-shares a single radix-4 partial-product row across WIDTH/2 cycles.
- Each cycle it recodes one multiplier digit in the selected scheme (MB, NR4SD-, NR4SD+), forms the row digit*A and accumulates it at weight 4^j.
- Sits in front of the multiplier array as a low-area alternative that produces the same results.
- Uses a valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 16, operand width; even, >= 4.
- ITER, WIDTH/2, derived digit count; not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE.
- a  in  WIDTH  signed multiplicand.
- b  in  WIDTH  signed multiplier.
- mode  in  2  recoding: 0=MB, 1=NR4SD-, 2=NR4SD+, 3=reserved, treated as MB.
- flush  in  1  synchronous abort.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- product  out  2*WIDTH  signed A*B.
- busy  out  1  high in RUN.
- dbg_one, dbg_two, dbg_neg  out  1 each  current digit magnitude 1, magnitude 2, negative; all 0 outside RUN.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1 after release; out_valid=0, busy=0, product=0, dbg_*=0.
  - Digit counter, recode carry and accumulator are cleared.
  - Reset asserted mid-RUN or mid-DONE discards the operation.
- States and transitions:
  - IDLE -> RUN on in_valid & in_ready & ~flush. a, b and mode are latched; counter j=0; carry c=0; acc=0.
  - RUN: one digit per clock, j=0..ITER-1. RUN -> DONE on the edge that processes j=ITER-1.
  - DONE: product=acc held stable, out_valid=1. DONE -> IDLE on out_ready.
  - flush=1 in any state -> IDLE on the next edge, no out_valid. flush takes priority over accept and over out_ready.
- Latency: out_valid rises ITER rising edges after the accepting edge (8 for WIDTH=16). Throughput is one product per ITER+2 cycles minimum.
- Backpressure: while out_ready=0, product and out_valid are held unchanged and in_ready=0.
- Digit recoding, with bits b[-1]=0 and b[i]:
  - MB: d = -2*b[2j+1] + b[2j] + b[2j-1]. No carry.
  - NR4SD- (j<ITER-1): v = 2*b[2j+1] + b[2j] + c.
    - v=0,1 -> d=v, c'=0.
    - v=2 -> d=-2, c'=1.
    - v=3 -> d=-1, c'=1.
    - v=4 -> d=0, c'=1.
  - NR4SD+ (j<ITER-1): v = 2*b[2j+1] + b[2j] + c.
    - v=0,1,2 -> d=v, c'=0.
    - v=3 -> d=-1, c'=1.
    - v=4 -> d=0, c'=1.
  - NR4SD last digit (j=ITER-1): d = -2*b[WIDTH-1] + b[WIDTH-2] + c, range -2..2, taken directly.
  - Encoding: dbg_one=(|d|==1), dbg_two=(|d|==2), dbg_neg=(d<0). For d=0 all three are 0.
- Accumulation:
  - Row = d*A as a (WIDTH+2)-bit signed value.
  - acc += sign_extend(row) << 2j, with acc 2*WIDTH bits, two's complement, modulo 2^(2*WIDTH).
  - The final acc equals signed A*B exactly for every mode.
- mode is sampled only at accept. Changes during RUN are ignored.

Decomposition:
- Package mult_ctrl_pkg:
  - MODE_MB=2'd0, MODE_NR4SDM=2'd1, MODE_NR4SDP=2'd2.
  - State encoding ST_IDLE, ST_RUN, ST_DONE.
  - Digit struct {one, two, neg}.
- Sub-module radix4_digit_recoder, purely combinational:
  - Inputs: b2 (bits 2j+1, 2j), b_prev (2j-1), carry_in, mode, last.
  - Outputs: one, two, neg, carry_out.
- The controller holds the FSM, counter, carry register, row formation and accumulator.

Test Plan:
- Basic MB: mode=0, a=3, b=5, accept at edge 0 -> out_valid at edge 8, product=32'h0000000F, busy high edges 1-8.
- Extreme operands: a=16'h8000, b=16'h8000, each of modes 0, 1, 2 -> product=32'h40000000 in all three.
- NR4SD-: mode=1, a=16'hFFFF, b=16'h7FFF -> product=32'hFFFF8001. dbg_neg=0 on the final digit, which is d=+2 from the carry.
- NR4SD+ with backpressure: mode=2, a=2, b=16'h5555 -> digits all +1, product=32'h0000AAAA. Hold out_ready=0 for 5 cycles -> product stable, in_ready=0; out_ready=1 -> IDLE next edge.
- Flush: flush asserted on the 3rd RUN cycle -> IDLE next edge, out_valid never rises. Then mode=0, a=7, b=-6 -> product=32'hFFFFFFD6.
- Async reset: drop rst_n mid-RUN, independent of clk -> out_valid=0, busy=0, product=0 immediately. After release in_ready=1, and a new op 100*100 -> 32'h00002710.
